// File: rtl/wts_adsr_envelope_multi_if.sv
// Bus bundle for the multi-channel ADSR envelope generator: service pulse,
// key events, register write port and the envelope sample stream.
interface wts_adsr_envelope_multi_if #(
  parameter int CH_NUM  = 8,
  parameter int RATE_W  = 12,
  parameter int LEVEL_W = 8
);
  localparam int CH_W = $clog2(CH_NUM);

  logic               active;
  logic [CH_NUM-1:0]  key_on;
  logic [CH_NUM-1:0]  key_release;
  logic [CH_NUM-1:0]  key_off;
  logic               reg_we;
  logic [CH_W-1:0]    reg_ch;
  logic [2:0]         reg_addr;
  logic [RATE_W-1:0]  reg_wdata;
  logic               env_valid;
  logic [CH_W-1:0]    env_ch;
  logic [LEVEL_W-1:0] env_level;
  logic [CH_NUM-1:0]  ch_busy;

  modport master (
    output active, key_on, key_release, key_off, reg_we, reg_ch, reg_addr, reg_wdata,
    input  env_valid, env_ch, env_level, ch_busy
  );

  modport slave (
    input  active, key_on, key_release, key_off, reg_we, reg_ch, reg_addr, reg_wdata,
    output env_valid, env_ch, env_level, ch_busy
  );
endinterface

// File: rtl/wts_adsr_envelope_multi.sv
// Time-multiplexed ADSR envelope generator: one shared datapath services one
// channel per active pulse, round-robin over CH_NUM channels.
module wts_adsr_envelope_multi #(
  parameter int CH_NUM  = 8,
  parameter int RATE_W  = 12,
  parameter int LEVEL_W = 8
) (
  input  logic                        clk,
  input  logic                        nreset,
  wts_adsr_envelope_multi_if.slave    bus
);
  localparam int CH_W    = $clog2(CH_NUM);
  localparam int CNT_W   = RATE_W + 4;
  localparam int CH_SPAN = 1 << CH_W;
  localparam logic [LEVEL_W-1:0] MAX = {1'b1, {(LEVEL_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_e;

  state_e             r_state [CH_NUM];
  logic [CNT_W-1:0]   r_cnt   [CH_NUM];
  logic [LEVEL_W-1:0] r_level [CH_NUM];
  logic [RATE_W-1:0]  r_ar    [CH_NUM];
  logic [RATE_W-1:0]  r_dr    [CH_NUM];
  logic [RATE_W-1:0]  r_sr    [CH_NUM];
  logic [RATE_W-1:0]  r_rr    [CH_NUM];
  logic [LEVEL_W-1:0] r_sl    [CH_NUM];
  logic [CH_NUM-1:0]  r_pend_on, r_pend_rel, r_pend_off;
  logic [CH_W-1:0]    r_ptr;
  logic               r_env_valid;
  logic [CH_W-1:0]    r_env_ch;
  logic [LEVEL_W-1:0] r_env_level;
  logic [CH_NUM-1:0]  r_busy;

  state_e             w_st_cur, w_st_nxt;
  logic [CNT_W-1:0]   w_cnt_cur, w_cnt_nxt;
  logic [LEVEL_W-1:0] w_lvl_cur, w_lvl_nxt, w_sl_eff;
  logic [RATE_W-1:0]  w_rate;
  logic               w_on, w_rel, w_off;
  logic [CH_NUM-1:0]  w_slot_mask;
  logic [CH_SPAN-1:0] w_ch_valid;
  logic               w_wr_ok;

  // Channel indices beyond CH_NUM are only reachable when CH_NUM is not a power of two.
  for (genvar g = 0; g < CH_SPAN; g++) begin : g_ch_valid
    assign w_ch_valid[g] = (g < CH_NUM);
  end

  assign w_wr_ok     = bus.reg_we & w_ch_valid[bus.reg_ch];
  assign w_slot_mask = bus.active ? (CH_NUM'(1) << r_ptr) : '0;

  // A key pulse on the servicing clk itself counts for this slot.
  assign w_on      = r_pend_on[r_ptr]  | bus.key_on[r_ptr];
  assign w_rel     = r_pend_rel[r_ptr] | bus.key_release[r_ptr];
  assign w_off     = r_pend_off[r_ptr] | bus.key_off[r_ptr];
  assign w_st_cur  = r_state[r_ptr];
  assign w_cnt_cur = r_cnt[r_ptr];
  assign w_lvl_cur = r_level[r_ptr];
  assign w_sl_eff  = (r_sl[r_ptr] > MAX) ? MAX : r_sl[r_ptr];

  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    w_rate    = '0;
    w_st_nxt  = w_st_cur;
    w_cnt_nxt = w_cnt_cur;
    w_lvl_nxt = w_lvl_cur;

    case (w_st_cur)
      ST_ATTACK:  w_rate = r_ar[r_ptr];
      ST_DECAY:   w_rate = r_dr[r_ptr];
      ST_SUSTAIN: w_rate = r_sr[r_ptr];
      ST_RELEASE: w_rate = r_rr[r_ptr];
      default:    w_rate = '0;
    endcase

    if (w_off) begin
      w_lvl_nxt = '0;
      w_st_nxt  = ST_IDLE;
    end else if (w_on) begin
      w_st_nxt  = ST_ATTACK;
      w_cnt_nxt = {r_ar[r_ptr], 4'hF};
      w_lvl_nxt = (r_ar[r_ptr] == '0) ? MAX : '0;
    end else begin
      if (w_rel) begin
        if (w_st_cur != ST_IDLE) w_st_nxt = ST_RELEASE;
      end else if (w_cnt_cur == '0) begin
        w_cnt_nxt = {w_rate, 4'hF};
        if (w_rate != '0) begin
          if (w_st_cur == ST_ATTACK)
            w_lvl_nxt = (w_lvl_cur >= MAX) ? MAX : w_lvl_cur + LEVEL_W'(1);
          else
            w_lvl_nxt = (w_lvl_cur == '0) ? '0 : w_lvl_cur - LEVEL_W'(1);
        end
      end else begin
        w_cnt_nxt = w_cnt_cur - CNT_W'(1);
      end

      // Silence check outranks the sustain-level check.
      if ((w_st_nxt inside {ST_DECAY, ST_SUSTAIN, ST_RELEASE}) && (w_lvl_nxt == '0))
        w_st_nxt = ST_IDLE;
      else if ((w_st_nxt == ST_ATTACK) && (w_lvl_nxt == MAX))
        w_st_nxt = ST_DECAY;
      else if ((w_st_nxt == ST_DECAY) && (w_lvl_nxt <= w_sl_eff))
        w_st_nxt = ST_SUSTAIN;
    end
  end

  // NOTE: the per-channel files are flop arrays, not RAM, so the async reset
  // clears every entry like any other register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
        r_level[i] <= '0;
      end
    end else if (bus.active) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_state[r_ptr] <= w_st_nxt;
      r_cnt[r_ptr]   <= w_cnt_nxt;
      r_level[r_ptr] <= w_lvl_nxt;
      r_ptr          <= (r_ptr == CH_W'(CH_NUM - 1)) ? '0 : r_ptr + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pend_on  <= '0;
      r_pend_rel <= '0;
      r_pend_off <= '0;
    end else begin
      r_pend_on  <= (r_pend_on  | bus.key_on)      & ~w_slot_mask;
      r_pend_rel <= (r_pend_rel | bus.key_release) & ~w_slot_mask;
      r_pend_off <= (r_pend_off | bus.key_off)     & ~w_slot_mask;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_ar[i] <= '0;
        r_dr[i] <= '0;
        r_sr[i] <= '0;
        r_rr[i] <= '0;
        r_sl[i] <= '0;
      end
    end else if (w_wr_ok) begin
      case (bus.reg_addr)
        3'd0:    r_ar[bus.reg_ch] <= bus.reg_wdata;
        3'd1:    r_dr[bus.reg_ch] <= bus.reg_wdata;
        3'd2:    r_sr[bus.reg_ch] <= bus.reg_wdata;
        3'd3:    r_rr[bus.reg_ch] <= bus.reg_wdata;
        3'd4:    r_sl[bus.reg_ch] <= bus.reg_wdata[LEVEL_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_env_valid <= 1'b0;
      r_env_ch    <= '0;
      r_env_level <= '0;
      r_busy      <= '0;
    end else begin
      r_env_valid <= bus.active;
      if (bus.active) begin
        r_env_ch      <= r_ptr;
        r_env_level   <= w_lvl_nxt;
        r_busy[r_ptr] <= (w_st_nxt != ST_IDLE);
      end
    end
  end

  assign bus.env_valid = r_env_valid;
  assign bus.env_ch    = r_env_ch;
  assign bus.env_level = r_env_level;
  assign bus.ch_busy   = r_busy;
endmodule

// File: tb/tb_wts_adsr_envelope_multi.sv
// Bench for wts_adsr_envelope_multi: a behavioural channel model feeds a
// scoreboard of expected samples, and scenario tasks check key milestones.
`timescale 1ns/1ps
module tb_wts_adsr_envelope_multi;
  localparam int CH_NUM  = 4;
  localparam int RATE_W  = 12;
  localparam int LEVEL_W = 8;
  localparam int CH_W    = 2;
  localparam int MAX     = 128;
  localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic clk;
  logic nreset;

  wts_adsr_envelope_multi_if #(.CH_NUM(CH_NUM), .RATE_W(RATE_W), .LEVEL_W(LEVEL_W)) bus ();

  wts_adsr_envelope_multi #(.CH_NUM(CH_NUM), .RATE_W(RATE_W), .LEVEL_W(LEVEL_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    int                lvl;
    logic [CH_NUM-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;

  // Behavioural channel model.
  int m_state [CH_NUM];
  int m_cnt   [CH_NUM];
  int m_lvl   [CH_NUM];
  int m_ar [CH_NUM], m_dr [CH_NUM], m_sr [CH_NUM], m_rr [CH_NUM], m_sl [CH_NUM];
  bit m_pon [CH_NUM], m_prel [CH_NUM], m_poff [CH_NUM];
  int m_ptr;

  // Last sample observed per channel.
  int                obs_lvl [CH_NUM];
  logic [CH_NUM-1:0] obs_busy;

  task automatic model_reset();
    for (int i = 0; i < CH_NUM; i++) begin
      m_state[i] = S_IDLE; m_cnt[i] = 0; m_lvl[i] = 0;
      m_ar[i] = 0; m_dr[i] = 0; m_sr[i] = 0; m_rr[i] = 0; m_sl[i] = 0;
      m_pon[i] = 0; m_prel[i] = 0; m_poff[i] = 0;
      obs_lvl[i] = 0;
    end
    obs_busy = '0;
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic model_slot(input int c, input bit on, input bit rel, input bit off);
    int r;
    int sl;
    case (m_state[c])
      S_ATK:   r = m_ar[c];
      S_DEC:   r = m_dr[c];
      S_SUS:   r = m_sr[c];
      S_REL:   r = m_rr[c];
      default: r = 0;
    endcase
    sl = (m_sl[c] > MAX) ? MAX : m_sl[c];
    if (off) begin
      m_lvl[c] = 0;
      m_state[c] = S_IDLE;
    end else if (on) begin
      m_state[c] = S_ATK;
      m_cnt[c] = m_ar[c] * 16 + 15;
      m_lvl[c] = (m_ar[c] == 0) ? MAX : 0;
    end else begin
      if (rel) begin
        if (m_state[c] != S_IDLE) m_state[c] = S_REL;
      end else if (m_cnt[c] == 0) begin
        m_cnt[c] = r * 16 + 15;
        if (r != 0) begin
          if (m_state[c] == S_ATK) m_lvl[c] = (m_lvl[c] + 1 > MAX) ? MAX : m_lvl[c] + 1;
          else                     m_lvl[c] = (m_lvl[c] == 0) ? 0 : m_lvl[c] - 1;
        end
      end else begin
        m_cnt[c] = m_cnt[c] - 1;
      end
      if ((m_state[c] == S_DEC || m_state[c] == S_SUS || m_state[c] == S_REL) && m_lvl[c] == 0)
        m_state[c] = S_IDLE;
      else if (m_state[c] == S_ATK && m_lvl[c] == MAX)
        m_state[c] = S_DEC;
      else if (m_state[c] == S_DEC && m_lvl[c] <= sl)
        m_state[c] = S_SUS;
    end
  endtask

  // One clk of stimulus, driven at the falling edge; expectation pushed when active.
  task automatic tick(input bit act,
                      input logic [CH_NUM-1:0] kon = '0,
                      input logic [CH_NUM-1:0] krel = '0,
                      input logic [CH_NUM-1:0] koff = '0,
                      input bit we = 0, input int wch = 0, input int waddr = 0, input int wdata = 0);
    int   c;
    exp_t e;
    c = -1;
    @(negedge clk);
    bus.active      = act;
    bus.key_on      = kon;
    bus.key_release = krel;
    bus.key_off     = koff;
    bus.reg_we      = we;
    bus.reg_ch      = CH_W'(wch);
    bus.reg_addr    = 3'(waddr);
    bus.reg_wdata   = RATE_W'(wdata);
    if (act) begin
      c = m_ptr;
      model_slot(c, m_pon[c] | kon[c], m_prel[c] | krel[c], m_poff[c] | koff[c]);
      m_pon[c] = 0; m_prel[c] = 0; m_poff[c] = 0;
      e.ch  = c;
      e.lvl = m_lvl[c];
      for (int i = 0; i < CH_NUM; i++) e.busy[i] = (m_state[i] != S_IDLE);
      exp_q.push_back(e);
      m_ptr = (m_ptr + 1) % CH_NUM;
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (i != c) begin
        m_pon[i]  = m_pon[i]  | kon[i];
        m_prel[i] = m_prel[i] | krel[i];
        m_poff[i] = m_poff[i] | koff[i];
      end
    end
    if (we && wch < CH_NUM) begin
      case (waddr)
        0: m_ar[wch] = wdata;
        1: m_dr[wch] = wdata;
        2: m_sr[wch] = wdata;
        3: m_rr[wch] = wdata;
        4: m_sl[wch] = wdata % 256;
        default: ;
      endcase
    end
  endtask

  task automatic run_slots(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    tick(1'b0, '0, '0, '0, 1'b1, ch, addr, data);
  endtask

  // Scoreboard: pop and compare each sample just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    checks++;
    if ((bus.env_valid === 1'b1) !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL valid_match: env_valid=%b with %0d samples expected", bus.env_valid, exp_q.size());
    end
    if (bus.env_valid === 1'b1) n_valid++;
    if (bus.env_valid === 1'b1 && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (bus.env_ch !== CH_W'(mon_e.ch)) begin
        errors++;
        $display("FAIL sb_env_ch: got %0d expected %0d", bus.env_ch, mon_e.ch);
      end
      checks++;
      if (bus.env_level !== LEVEL_W'(mon_e.lvl)) begin
        errors++;
        $display("FAIL sb_env_level ch%0d: got %0d expected %0d", mon_e.ch, bus.env_level, mon_e.lvl);
      end
      checks++;
      if (bus.ch_busy !== mon_e.busy) begin
        errors++;
        $display("FAIL sb_ch_busy: got %b expected %b", bus.ch_busy, mon_e.busy);
      end
      obs_lvl[bus.env_ch] = int'(bus.env_level);
      obs_busy = bus.ch_busy;
    end else if (exp_q.size() != 0) begin
      exp_q.delete();
    end
  end

  task automatic test_reset();
    bus.active = 0; bus.key_on = '0; bus.key_release = '0; bus.key_off = '0;
    bus.reg_we = 0; bus.reg_ch = '0; bus.reg_addr = '0; bus.reg_wdata = '0;
    nreset = 1'b0;
    model_reset();
    #12;
    checks++; if (bus.env_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.env_valid); end
    checks++; if (bus.env_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", bus.env_ch); end
    checks++; if (bus.env_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.env_level); end
    checks++; if (bus.ch_busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.ch_busy); end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_attack_instant();
    wr(1, 0, 0); wr(1, 4, 64); wr(1, 1, 0);
    tick(1'b0, 4'b0010);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[1] !== MAX) begin errors++; $display("FAIL ar0_level: got %0d expected 128", obs_lvl[1]); end
    checks++; if (obs_busy[1] !== 1'b1) begin errors++; $display("FAIL ar0_busy: got %b expected 1", obs_busy[1]); end
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[1] !== MAX) begin errors++; $display("FAIL ar0_decay_hold: got %0d expected 128", obs_lvl[1]); end
  endtask

  task automatic test_attack_ramp();
    wr(0, 0, 1);
    tick(1'b0, 4'b0001);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[0] !== 0) begin errors++; $display("FAIL ramp_start: got %0d expected 0", obs_lvl[0]); end
    checks++; if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b expected 1", obs_busy[0]); end
    run_slots(4 * 31); tick(1'b0);
    checks++; if (obs_lvl[0] !== 0) begin errors++; $display("FAIL ramp_slot31: got %0d expected 0", obs_lvl[0]); end
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[0] !== 1) begin errors++; $display("FAIL ramp_slot32: got %0d expected 1", obs_lvl[0]); end
    run_slots(4 * (4095 - 32)); tick(1'b0);
    checks++; if (obs_lvl[0] !== 127) begin errors++; $display("FAIL ramp_slot4095: got %0d expected 127", obs_lvl[0]); end
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[0] !== MAX) begin errors++; $display("FAIL ramp_slot4096: got %0d expected 128", obs_lvl[0]); end
    run_slots(4 * 40); tick(1'b0);
    checks++; if (obs_lvl[0] !== MAX) begin errors++; $display("FAIL ramp_decay_hold: got %0d expected 128", obs_lvl[0]); end
  endtask

  task automatic test_decay_sustain();
    wr(0, 1, 1); wr(0, 4, 100); wr(0, 2, 0);
    run_slots(4 * 1000); tick(1'b0);
    checks++; if (obs_lvl[0] !== 100) begin errors++; $display("FAIL decay_to_sl: got %0d expected 100", obs_lvl[0]); end
    run_slots(4 * 1000); tick(1'b0);
    checks++; if (obs_lvl[0] !== 100) begin errors++; $display("FAIL sustain_hold: got %0d expected 100", obs_lvl[0]); end
    checks++; if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL sustain_busy: got %b expected 1", obs_busy[0]); end
  endtask

  task automatic test_release();
    wr(2, 0, 0); wr(2, 1, 1); wr(2, 4, 200); wr(2, 2, 0); wr(2, 3, 1);
    tick(1'b0, 4'b0100);
    run_slots(4 * 100); tick(1'b0);
    checks++; if (obs_lvl[2] !== MAX) begin errors++; $display("FAIL sl200_sustain: got %0d expected 128", obs_lvl[2]); end
    tick(1'b0, '0, 4'b0100);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[2] !== MAX) begin errors++; $display("FAIL rel_first_slot: got %0d expected 128", obs_lvl[2]); end
    checks++; if (obs_busy[2] !== 1'b1) begin errors++; $display("FAIL rel_busy: got %b expected 1", obs_busy[2]); end
    run_slots(4 * 4200); tick(1'b0);
    checks++; if (obs_lvl[2] !== 0) begin errors++; $display("FAIL rel_to_zero: got %0d expected 0", obs_lvl[2]); end
    checks++; if (obs_busy[2] !== 1'b0) begin errors++; $display("FAIL rel_idle: got %b expected 0", obs_busy[2]); end
    tick(1'b0, '0, 4'b1000);
    run_slots(4); tick(1'b0);
    checks++; if (obs_busy[3] !== 1'b0) begin errors++; $display("FAIL rel_on_idle: got %b expected 0", obs_busy[3]); end
  endtask

  task automatic test_off_priority();
    wr(3, 0, 0);
    tick(1'b0, 4'b1000, '0, 4'b1000);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[3] !== 0) begin errors++; $display("FAIL off_same_clk_level: got %0d expected 0", obs_lvl[3]); end
    checks++; if (obs_busy[3] !== 1'b0) begin errors++; $display("FAIL off_same_clk_busy: got %b expected 0", obs_busy[3]); end
    tick(1'b0, '0, '0, 4'b1000);
    tick(1'b0, 4'b1000);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[3] !== 0) begin errors++; $display("FAIL off_then_on_level: got %0d expected 0", obs_lvl[3]); end
    checks++; if (obs_busy[3] !== 1'b0) begin errors++; $display("FAIL off_then_on_busy: got %b expected 0", obs_busy[3]); end
    run_slots(3);
    tick(1'b1, 4'b1000);
    tick(1'b0);
    checks++; if (obs_lvl[3] !== MAX) begin errors++; $display("FAIL on_in_slot_clk: got %0d expected 128", obs_lvl[3]); end
    tick(1'b0, '0, '0, 4'b0001);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[0] !== 0) begin errors++; $display("FAIL off_sustain_level: got %0d expected 0", obs_lvl[0]); end
    checks++; if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL off_sustain_busy: got %b expected 0", obs_busy[0]); end
  endtask

  task automatic test_reg_ignore();
    tick(1'b0, '0, '0, 4'b1000);
    run_slots(4);
    wr(3, 0, 0); wr(3, 1, 1); wr(3, 4, 120); wr(3, 2, 1);
    wr(3, 5, 0); wr(3, 6, 0); wr(3, 7, 0);
    tick(1'b0, 4'b1000);
    run_slots(4 * 301); tick(1'b0);
    checks++; if (obs_lvl[3] !== 119) begin errors++; $display("FAIL reg_ignore_level: got %0d expected 119", obs_lvl[3]); end
    checks++; if (obs_busy[3] !== 1'b1) begin errors++; $display("FAIL reg_ignore_busy: got %b expected 1", obs_busy[3]); end
  endtask

  task automatic test_back_to_back();
    int start;
    start = n_valid;
    repeat (6) begin tick(1'b1); tick(1'b0); end
    run_slots(5);
    tick(1'b0); tick(1'b0);
    checks++;
    if (n_valid - start !== 11) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d expected 11", n_valid - start);
    end
  endtask

  task automatic test_reset_mid_note();
    tick(1'b1);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.env_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.env_valid); end
    checks++; if (bus.env_level !== '0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", bus.env_level); end
    checks++; if (bus.ch_busy !== '0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.ch_busy); end
    repeat (2) tick(1'b0);
    nreset = 1'b1;
    repeat (3) tick(1'b0);
    tick(1'b0, 4'b0010);
    run_slots(4); tick(1'b0);
    checks++; if (obs_lvl[1] !== MAX) begin errors++; $display("FAIL postrst_level: got %0d expected 128", obs_lvl[1]); end
    checks++; if (bus.env_ch !== CH_W'(3)) begin errors++; $display("FAIL postrst_ch: got %0d expected 3", bus.env_ch); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_attack_instant();
    test_attack_ramp();
    test_decay_sustain();
    test_release();
    test_off_priority();
    test_reg_ignore();
    test_back_to_back();
    test_reset_mid_note();
    tick(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d samples outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wts_adsr_envelope_multi.md
# wts_adsr_envelope_multi

Time-multiplexed, parametrised ADSR envelope generator serving CH_NUM wave-table channels from a single datapath. Per-channel rates and sustain levels are held in internal register files written through a small register port. Key events arrive as per-channel pulse vectors. One channel is serviced per `active` timing pulse, and its envelope is streamed out as channel/level/valid for the channel mixer.

## Interface
- CH_NUM, 8, number of channels (≥2); CH_W = $clog2(CH_NUM)
- RATE_W, 12, rate register width; per-channel counter width is RATE_W+4
- LEVEL_W, 8, envelope width; full scale MAX = 2^(LEVEL_W-1), which is 128 at the default
- nreset  in  1  asynchronous reset, active-low
- clk  in  1  system clock
- active  in  1  service-slot pulse, one clk wide (3.579 MHz timing)
- key_on  in  CH_NUM  per-channel one-clk pulse: start note
- key_release  in  CH_NUM  per-channel one-clk pulse: enter release
- key_off  in  CH_NUM  per-channel one-clk pulse: immediate silence
- reg_we  in  1  register write strobe
- reg_ch  in  CH_W  target channel; values ≥CH_NUM are ignored
- reg_addr  in  3  0 AR, 1 DR, 2 SR, 3 RR, 4 SL; 5–7 are ignored
- reg_wdata  in  RATE_W  write data; SL uses the low LEVEL_W bits
- env_valid  out  1  one-clk pulse: env_ch/env_level updated
- env_ch  out  CH_W  channel of the current sample
- env_level  out  LEVEL_W  envelope value, 0..MAX
- ch_busy  out  CH_NUM  bit n = channel n state ≠ IDLE

## Operation
- **Per-channel storage.**
  - state: IDLE/ATTACK/DECAY/SUSTAIN/RELEASE.
  - counter: RATE_W+4 bits.
  - level: LEVEL_W bits.
  - pending flags: on/rel/off.
  - registers AR, DR, SR, RR, SL.
  - All reset to 0; states reset to IDLE.
- **Key capture.** Key pulses set the matching pending flag on any clk.
  - Flags are consumed at the channel's next service slot.
  - A pulse arriving on the servicing clk itself counts for that slot: effective flag = latched | input.
  - All three of the channel's flags clear when its slot is processed.
- **Service pointer.** ptr starts at 0 and advances by 1 per `active`, wrapping CH_NUM-1→0. Only channel ptr is updated in that cycle.
- **Rate selection.** Active rate R: ATTACK→AR, DECAY→DR, SUSTAIN→SR, RELEASE→RR, IDLE→0.
- **Slot processing**, first match wins:
  1. **off:** level=0, state=IDLE.
  2. **on:** state=ATTACK; counter={AR,4'b1111}; level=MAX if AR==0, else level=0.
  3. **rel:** if state≠IDLE, state=RELEASE. The counter and level are not touched.
  4. **counter==0:** counter={R,4'b1111}.
     - If R≠0: ATTACK steps level+1, saturating at MAX; other states step level−1, saturating at 0.
     - If R==0: level holds.
  5. **Otherwise:** counter−1.
- **State transitions.** Evaluated in the same slot on the level value after processing. Not applied when step 1 or 2 fired.
  - ATTACK with level==MAX → DECAY.
  - DECAY with level≤SL_eff → SUSTAIN, where SL_eff = min(SL, MAX).
  - DECAY/SUSTAIN/RELEASE with level==0 → IDLE.
  - The IDLE check takes priority over the SUSTAIN check.
- **SUSTAIN behaviour.** SUSTAIN decays at SR. SR=0 holds the level indefinitely.
- **Register writes.** Take effect at the next clk. Values are used from the next slot of that channel; the counter in flight is not reloaded.

## Timing
- **Output.** The clk after each `active`:
  - env_valid=1.
  - env_ch = the serviced ptr.
  - env_level = the channel's updated level.
- ch_busy is registered and reflects the post-slot state the same clk.
- **Step period.** One step per (R+1)·16 slots of a channel, i.e. (R+1)·16·CH_NUM `active` pulses.
- **Reset values.** Async reset clears:
  - all state, pointer and pending flags;
  - all outputs to 0: env_valid=0, env_ch=0, env_level=0, ch_busy=0.
- **Reset mid-note.** Reset during a note aborts it; no output follows until the next `active`.
- **Back-to-back `active`** on consecutive clks is legal. Each one produces one env_valid.

## Test plan
Bench defaults: CH_NUM=4, LEVEL_W=8, RATE_W=12.
- AR=0, SL=64, DR=0 on ch1; key_on[1] → at ch1's next slot, env_ch=1 and env_level=128. On the following ch1 slot the state is DECAY and the level holds at 128.
- AR=1 on ch0; key_on[0] → env_level=0, then rises by 1 every 32 ch0 slots (128 `active` pulses). Reaches 128 after 4096 slots, then enters DECAY.
- DR=0x001, SL=100, starting from level 128 in DECAY → the level reaches 100 and the state becomes SUSTAIN. With SR=0 the level holds at 100 for 1000 slots.
- key_release[2] mid-SUSTAIN with RR=0x001 → decrements to 0, then ch_busy[2] clears. key_release on an IDLE channel leaves it IDLE.
- key_on[3] and key_off[3] in the same clk → off wins: level 0, IDLE. key_off then key_on in separate clks before the slot → off wins (both flags pending).
- Register write to reg_ch=5 or reg_addr=6 → no register changes. SL=200 behaves as SL=128.
